// File: rtl/req_arbiter_8ch.sv
`default_nettype none
// ============================================================================
// Module   : req_arbiter_8ch
// Brief    : Single-owner arbiter, fixed-priority or round-robin, with
//            release-on-done, release-on-drop and optional hold timeout.
// Revision : 1.0  initial release
// ============================================================================
module req_arbiter_8ch #(
    parameter int NREQ     = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             rr_mode,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int                c_CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [NREQ-1:0]   c_ONE       = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_gnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_timeout;
    logic [IDX_W-1:0]   r_last;
    logic [c_CNT_W-1:0] r_hold;

    state_t             w_state_nxt;
    logic [NREQ-1:0]    w_gnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_timeout_nxt;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [c_CNT_W-1:0] w_hold_nxt;

    logic [IDX_W-1:0]   w_fp_idx;
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_rr_hit;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_hold_exp;
    logic               w_owner_req;
    logic               w_release;

    // Fixed priority: ascending scan, so the highest set bit is written last.
    always_comb begin
        w_fp_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                w_fp_idx = IDX_W'(i);
            end
        end
    end

    // Round-robin: scan from last_idx+1 upward; the previous owner comes last.
    always_comb begin
        logic [IDX_W-1:0] cand;
        w_rr_idx = '0;
        w_rr_hit = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = r_last + IDX_W'(k);
            if (!w_rr_hit && req[cand]) begin
                w_rr_idx = cand;
                w_rr_hit = 1'b1;
            end
        end
    end

    assign w_win_idx   = rr_mode ? w_rr_idx : w_fp_idx;
    assign w_owner_req = req[r_idx];
    assign w_hold_exp  = (MAX_HOLD != 0) && (r_hold == c_HOLD_LAST);
    assign w_release   = done || !w_owner_req || w_hold_exp;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_idx;
        w_timeout_nxt = 1'b0;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = c_ONE << w_win_idx;
                    w_idx_nxt   = w_win_idx;
                    w_hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // Drop to IDLE for one bubble cycle before any new grant.
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = '0;
                    w_last_nxt    = r_idx;
                    w_timeout_nxt = w_hold_exp && !done && w_owner_req;
                end else begin
                    w_hold_nxt = r_hold + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_timeout <= 1'b0;
            r_last    <= IDX_W'(NREQ - 1);
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_idx     <= w_idx_nxt;
            r_timeout <= w_timeout_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = |r_gnt;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter_8ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_arbiter_8ch
// Brief    : Scoreboard bench for req_arbiter_8ch: directed scenarios plus a
//            randomized run, all checked against a behavioural reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_req_arbiter_8ch;

    localparam int NREQ     = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic             rr_mode;
    logic             done;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    req_arbiter_8ch #(
        .NREQ     (NREQ),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_mode   (rr_mode),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [IDX_W-1:0] idx;
        logic             valid;
        logic             to;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    int   m_busy  = 0;
    int   m_owner = 0;
    int   m_last  = NREQ - 1;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input logic rr);
        if (rr) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (r[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
            end
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end
        return 0;
    endfunction

    // Drive one cycle, predict outputs after the edge, then compare.
    task automatic step(input logic [NREQ-1:0] r, input logic rr, input logic d, input logic rs);
        exp_t e;
        exp_t a;
        bit   hold_exp;
        req     = r;
        rr_mode = rr;
        done    = d;
        rst     = rs;
        if (rs) begin
            m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_hold = 0; m_to = 1'b0;
        end else if (m_busy == 0) begin
            m_to = 1'b0;
            if (r != '0) begin
                m_owner = pick(r, rr);
                m_busy  = 1;
                m_hold  = 0;
            end
        end else begin
            hold_exp = (MAX_HOLD != 0) && (m_hold == MAX_HOLD - 1);
            if (d || !r[m_owner] || hold_exp) begin
                m_to   = hold_exp && !d && r[m_owner];
                m_busy = 0;
                m_last = m_owner;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end
        e.gnt   = (m_busy != 0) ? (NREQ'(1) << m_owner) : '0;
        e.idx   = IDX_W'(m_owner);
        e.valid = (m_busy != 0);
        e.to    = m_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        a = sb.pop_front();
        check("sb_gnt",     32'(gnt),       32'(a.gnt));
        check("sb_idx",     32'(gnt_idx),   32'(a.idx));
        check("sb_valid",   32'(gnt_valid), 32'(a.valid));
        check("sb_timeout", 32'(timeout),   32'(a.to));
    endtask

    initial begin
        int cnt;
        rst = 1'b1; req = '0; rr_mode = 1'b0; done = 1'b0;

        // Reset and idle
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        check("rst_gnt", 32'(gnt), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b0, 1'b1, 1'b0);
            check("idle_valid", 32'(gnt_valid), 32'h0);
        end

        // Fixed priority and release by done
        step(8'h26, 1'b0, 1'b0, 1'b0);
        check("fp_gnt", 32'(gnt), 32'h20);
        check("fp_idx", 32'(gnt_idx), 32'h5);
        step(8'h26, 1'b0, 1'b1, 1'b0);
        check("fp_bubble", 32'(gnt), 32'h0);
        check("fp_idx_hold", 32'(gnt_idx), 32'h5);
        step(8'h06, 1'b0, 1'b0, 1'b0);
        check("fp_next", 32'(gnt), 32'h04);
        step(8'h00, 1'b0, 1'b1, 1'b0);

        // Round-robin rotation including 7->0 wrap
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'hFF, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            check("rr_idx", 32'(gnt_idx), 32'(k % NREQ));
            check("rr_valid", 32'(gnt_valid), 32'h1);
            step(8'hFF, 1'b1, 1'b1, 1'b0);
            check("rr_bubble", 32'(gnt_valid), 32'h0);
            step(8'hFF, 1'b1, 1'b0, 1'b0);
        end
        step(8'h00, 1'b1, 1'b1, 1'b0);

        // Hold timeout
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h08, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (gnt == 8'h08 && cnt < 40) begin
            cnt++;
            step(8'h08, 1'b0, 1'b0, 1'b0);
        end
        check("to_len", 32'(cnt), 32'd16);
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_gnt", 32'(gnt), 32'h0);
        step(8'h08, 1'b0, 1'b0, 1'b0);
        check("to_regrant", 32'(gnt), 32'h08);
        check("to_clear", 32'(timeout), 32'h0);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        // Reset mid-grant, then RR pick from last_idx=7
        step(8'h40, 1'b0, 1'b0, 1'b0);
        step(8'h40, 1'b0, 1'b0, 1'b0);
        check("mid_gnt", 32'(gnt), 32'h40);
        step(8'h40, 1'b0, 1'b0, 1'b1);
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_idx", 32'(gnt_idx), 32'h0);
        step(8'h41, 1'b1, 1'b0, 1'b0);
        check("rst_rr_idx", 32'(gnt_idx), 32'h0);
        step(8'h00, 1'b1, 1'b0, 1'b0);

        // Owner drops request; non-owner and rr_mode changes ignored while granted
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h04, 1'b0, 1'b0, 1'b0);
        step(8'h14, 1'b1, 1'b0, 1'b0);
        check("nopre_gnt", 32'(gnt), 32'h04);
        step(8'h04, 1'b0, 1'b0, 1'b0);
        check("nopre_gnt2", 32'(gnt), 32'h04);
        step(8'h10, 1'b1, 1'b0, 1'b0);
        check("drop_gnt", 32'(gnt), 32'h0);
        step(8'h10, 1'b0, 1'b0, 1'b0);
        check("drop_next", 32'(gnt), 32'h10);

        // Randomized run with persistent request patterns
        begin
            logic [NREQ-1:0] r;
            logic            rr;
            r  = 8'(($urandom));
            rr = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 7) == 0) r  = 8'($urandom);
                if ($urandom_range(0, 15) == 0) rr = ~rr;
                step(r, rr, ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
